sram_controller: RTL and testbench

Multi-cycle access sequencer between the MEM stage and an off-chip 16-bit-wide SRAM. It replaces the single-cycle data memory. It converts each 32-bit load/store from the MEM stage into two 16-bit SRAM half-word transfers. While the access is in flight it holds `ready` low; the hazard/pipeline-control logic uses `~ready` as the freeze signal for every pipeline register.

---
 rtl/sram_controller_if.sv | 26 ++
 rtl/sram_controller.sv | 173 +++++++++++++++++
 tb/tb_sram_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// MEM-stage and SRAM-bus signal bundle for the multi-cycle SRAM access sequencer.
interface sram_controller_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic [15:0] SRAM_DQ_in;
    logic        SRAM_WE_N;

    // Pipeline side together with the external SRAM data pins
    modport master (
        output MEM_R_EN, MEM_W_EN, address, wdata, SRAM_DQ_in,
        input  rdata, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
    );

    // Controller side
    modport slave (
        input  MEM_R_EN, MEM_W_EN, address, wdata, SRAM_DQ_in,
        output rdata, ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
    );
endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage load/store into two 16-bit SRAM transfers
// (low half then high half) and holds ready low while the access is in flight.
module sram_controller #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam logic [31:0] BASE     = 32'(BASE_ADDR);
    localparam logic [3:0]  LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t      r_state;
    state_t      w_stateNext;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cntNext;
    logic [16:0] r_word;
    logic [16:0] w_wordNext;
    logic [31:0] r_wdata;
    logic [31:0] w_wdataNext;
    logic        r_isWrite;
    logic        w_isWriteNext;
    logic [15:0] r_rdataLo;
    logic [15:0] w_rdataLoNext;
    logic [31:0] r_rdata;
    logic [31:0] w_rdataNext;

    logic [17:0] r_sramAddr;
    logic [17:0] w_sramAddrNext;
    logic [15:0] r_sramDqOut;
    logic [15:0] w_sramDqOutNext;
    logic        r_sramDqOe;
    logic        w_sramDqOeNext;
    logic        r_sramWeN;
    logic        w_sramWeNNext;

    logic        w_request;
    logic        w_lastCycle;
    logic [31:0] w_offset;
    logic        w_unusedOffsetBits;

    assign w_request   = bus.MEM_R_EN | bus.MEM_W_EN;
    assign w_lastCycle = (r_cnt == LAST_CNT);
    assign w_offset    = bus.address - BASE;

    // Only offset[18:2] selects a word; the rest is deliberately discarded
    assign w_unusedOffsetBits = ^{w_offset[31:19], w_offset[1:0]};

    // Freeze is combinational so the pipeline stalls in the very cycle the request appears
    assign bus.ready       = !(w_request && (r_state != DONE));
    assign bus.rdata       = r_rdata;
    assign bus.SRAM_ADDR   = r_sramAddr;
    assign bus.SRAM_DQ_out = r_sramDqOut;
    assign bus.SRAM_DQ_oe  = r_sramDqOe;
    assign bus.SRAM_WE_N   = r_sramWeN;

    // Next-state logic: latch the request in IDLE, step through both halves, capture read data
    always_comb begin
        w_stateNext   = r_state;
        w_wordNext    = r_word;
        w_wdataNext   = r_wdata;
        w_isWriteNext = r_isWrite;
        w_rdataLoNext = r_rdataLo;
        w_rdataNext   = r_rdata;
        case (r_state)
            IDLE: begin
                if (w_request) begin
                    w_stateNext   = LOW;
                    w_wordNext    = w_offset[18:2];
                    w_wdataNext   = bus.wdata;
                    w_isWriteNext = bus.MEM_W_EN;
                end
            end
            LOW: begin
                if (w_lastCycle) begin
                    if (!r_isWrite) begin
                        w_rdataLoNext = bus.SRAM_DQ_in;
                    end
                    w_stateNext = HIGH;
                end
            end
            HIGH: begin
                if (w_lastCycle) begin
                    if (!r_isWrite) begin
                        w_rdataNext = {bus.SRAM_DQ_in, r_rdataLo};
                    end
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Hold-cycle counter: advances only while staying in LOW or HIGH, cleared otherwise
    always_comb begin
        w_cntNext = 4'd0;
        if ((w_stateNext == r_state) && ((r_state == LOW) || (r_state == HIGH))) begin
            w_cntNext = r_cnt + 4'd1;
        end
    end

    // SRAM pins decoded from the upcoming state so the registered outputs line up with it
    always_comb begin
        w_sramAddrNext  = 18'd0;
        w_sramDqOutNext = 16'd0;
        w_sramDqOeNext  = 1'b0;
        w_sramWeNNext   = 1'b1;
        case (w_stateNext)
            LOW: begin
                w_sramAddrNext = {w_wordNext, 1'b0};
                if (w_isWriteNext) begin
                    w_sramDqOutNext = w_wdataNext[15:0];
                    w_sramDqOeNext  = 1'b1;
                    w_sramWeNNext   = 1'b0;
                end
            end
            HIGH: begin
                w_sramAddrNext = {w_wordNext, 1'b1};
                if (w_isWriteNext) begin
                    w_sramDqOutNext = w_wdataNext[31:16];
                    w_sramDqOeNext  = 1'b1;
                    w_sramWeNNext   = 1'b0;
                end
            end
            default: begin
            end
        endcase
    end

    // State, latched request, read data and glitch-free SRAM pin registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_word      <= 17'd0;
            r_wdata     <= 32'd0;
            r_isWrite   <= 1'b0;
            r_rdataLo   <= 16'd0;
            r_rdata     <= 32'd0;
            r_sramAddr  <= 18'd0;
            r_sramDqOut <= 16'd0;
            r_sramDqOe  <= 1'b0;
            r_sramWeN   <= 1'b1;
        end else begin
            r_state     <= w_stateNext;
            r_cnt       <= w_cntNext;
            r_word      <= w_wordNext;
            r_wdata     <= w_wdataNext;
            r_isWrite   <= w_isWriteNext;
            r_rdataLo   <= w_rdataLoNext;
            r_rdata     <= w_rdataNext;
            r_sramAddr  <= w_sramAddrNext;
            r_sramDqOut <= w_sramDqOutNext;
            r_sramDqOe  <= w_sramDqOeNext;
            r_sramWeN   <= w_sramWeNNext;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: a main A=2 instance backed by a small SRAM model,
// plus A=1 and A=3 instances used to measure stall length.
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic [3:1]  rEnVec;
    logic [3:1]  wEnVec;
    logic [31:0] addrV;
    logic [31:0] wdataV;
    int          compared;
    int          mismatched;
    int          lowCount;
    logic [15:0] mem [0:255];

    sram_controller_if bus1 ();
    sram_controller_if bus2 ();
    sram_controller_if bus3 ();

    sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    sram_controller #(.BASE_ADDR(1024), .ACCESS_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    assign bus1.MEM_R_EN   = rEnVec[1];
    assign bus1.MEM_W_EN   = wEnVec[1];
    assign bus1.address    = addrV;
    assign bus1.wdata      = wdataV;
    assign bus1.SRAM_DQ_in = 16'h0000;
    assign bus2.MEM_R_EN   = rEnVec[2];
    assign bus2.MEM_W_EN   = wEnVec[2];
    assign bus2.address    = addrV;
    assign bus2.wdata      = wdataV;
    assign bus2.SRAM_DQ_in = mem[bus2.SRAM_ADDR[7:0]];
    assign bus3.MEM_R_EN   = rEnVec[3];
    assign bus3.MEM_W_EN   = wEnVec[3];
    assign bus3.address    = addrV;
    assign bus3.wdata      = wdataV;
    assign bus3.SRAM_DQ_in = 16'h0000;

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Asynchronous-read, clocked-write SRAM model on the main instance
    always @(posedge clk) begin
        if (!bus2.SRAM_WE_N) begin
            mem[bus2.SRAM_ADDR[7:0]] <= bus2.SRAM_DQ_out;
        end
    end

    function automatic logic readyOf(input int which);
        case (which)
            1:       return bus1.ready;
            3:       return bus3.ready;
            default: return bus2.ready;
        endcase
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int which, input logic r, input logic w,
                                 input logic [31:0] a, input logic [31:0] d);
        rEnVec        = 3'b000;
        wEnVec        = 3'b000;
        rEnVec[which] = r;
        wEnVec[which] = w;
        addrV         = a;
        wdataV        = d;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic countLow(input int which, output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (readyOf(which)) break;
            n++;
            nextCycle();
        end
    endtask

    task automatic measureStall(input int which, input logic r, input logic w,
                                input logic [31:0] a, input logic [31:0] d, output int n);
        applyStimulus(which, r, w, a, d);
        countLow(which, n);
    endtask

    task automatic goIdle();
        nextCycle();
        applyStimulus(2, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic doStoreCheck(input string tag, input logic [31:0] a, input logic [31:0] d,
                                input logic [17:0] expLo);
        applyStimulus(2, 1'b0, 1'b1, a, d);
        checkOutput({tag, "_c0_ready"}, {31'd0, bus2.ready}, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            nextCycle();
            checkOutput({tag, "_addr"}, {14'd0, bus2.SRAM_ADDR},
                        {14'd0, (c <= 2) ? expLo : (expLo + 18'd1)});
            checkOutput({tag, "_dq"}, {16'd0, bus2.SRAM_DQ_out},
                        {16'd0, (c <= 2) ? d[15:0] : d[31:16]});
            checkOutput({tag, "_wen"}, {31'd0, bus2.SRAM_WE_N}, 32'd0);
            checkOutput({tag, "_oe"}, {31'd0, bus2.SRAM_DQ_oe}, 32'd1);
            checkOutput({tag, "_ready"}, {31'd0, bus2.ready}, 32'd0);
        end
        nextCycle();
        checkOutput({tag, "_done_ready"}, {31'd0, bus2.ready}, 32'd1);
        checkOutput({tag, "_done_wen"}, {31'd0, bus2.SRAM_WE_N}, 32'd1);
        checkOutput({tag, "_done_addr"}, {14'd0, bus2.SRAM_ADDR}, 32'd0);
        checkOutput({tag, "_done_oe"}, {31'd0, bus2.SRAM_DQ_oe}, 32'd0);
        goIdle();
    endtask

    // Directed sequence of steps
    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        applyStimulus(2, 1'b1, 1'b0, 32'd1028, 32'd0);

        // Reset held two cycles with a load pending
        nextCycle();
        nextCycle();
        checkOutput("rst_wen", {31'd0, bus2.SRAM_WE_N}, 32'd1);
        checkOutput("rst_oe", {31'd0, bus2.SRAM_DQ_oe}, 32'd0);
        checkOutput("rst_addr", {14'd0, bus2.SRAM_ADDR}, 32'd0);
        checkOutput("rst_rdata", bus2.rdata, 32'd0);

        // Releasing reset with the load still pending must start from IDLE
        rst = 1'b0;
        #1;
        countLow(2, lowCount);
        checkOutput("rst_release_stall", 32'(lowCount), 32'd5);
        goIdle();
        checkOutput("idle_ready", {31'd0, bus2.ready}, 32'd1);

        // Store then load
        doStoreCheck("store1028", 32'd1028, 32'hDEADBEEF, 18'd2);
        checkOutput("mem2", {16'd0, mem[2]}, 32'h0000BEEF);
        checkOutput("mem3", {16'd0, mem[3]}, 32'h0000DEAD);
        measureStall(2, 1'b1, 1'b0, 32'd1028, 32'd0, lowCount);
        checkOutput("load1028_stall", 32'(lowCount), 32'd5);
        checkOutput("load1028_rdata", bus2.rdata, 32'hDEADBEEF);
        goIdle();
        checkOutput("rdata_held", bus2.rdata, 32'hDEADBEEF);
        checkOutput("mem2_after_read", {16'd0, mem[2]}, 32'h0000BEEF);

        // Both enables high behaves as a write and leaves rdata alone
        measureStall(2, 1'b1, 1'b1, 32'd1024, 32'h12345678, lowCount);
        checkOutput("both_stall", 32'(lowCount), 32'd5);
        checkOutput("both_rdata_kept", bus2.rdata, 32'hDEADBEEF);
        goIdle();
        checkOutput("both_mem0", {16'd0, mem[0]}, 32'h00005678);
        checkOutput("both_mem1", {16'd0, mem[1]}, 32'h00001234);
        measureStall(2, 1'b1, 1'b0, 32'd1024, 32'd0, lowCount);
        checkOutput("load1024_rdata", bus2.rdata, 32'h12345678);
        goIdle();

        // Address handling: top word, wrap to word 0, ignored byte offset
        doStoreCheck("store_top", 32'd1024 + 32'h0007FFFC, 32'hA5A55A5A, 18'h3FFFE);
        doStoreCheck("store_wrap", 32'd1024 + 32'h00080000, 32'h0BADF00D, 18'h00000);
        measureStall(2, 1'b1, 1'b0, 32'd1030, 32'd0, lowCount);
        checkOutput("load1030_rdata", bus2.rdata, 32'hDEADBEEF);
        goIdle();
        measureStall(2, 1'b1, 1'b0, 32'd1024, 32'd0, lowCount);
        checkOutput("load_wrap_rdata", bus2.rdata, 32'h0BADF00D);
        goIdle();

        // Stall length for the other access-cycle settings
        measureStall(1, 1'b1, 1'b0, 32'd1028, 32'd0, lowCount);
        checkOutput("stall_a1", 32'(lowCount), 32'd3);
        goIdle();
        measureStall(3, 1'b1, 1'b0, 32'd1028, 32'd0, lowCount);
        checkOutput("stall_a3", 32'(lowCount), 32'd7);
        goIdle();

        // Reset in cycle 2 of a store
        applyStimulus(2, 1'b0, 1'b1, 32'd1028, 32'h11112222);
        nextCycle();
        nextCycle();
        checkOutput("midrst_c2_wen", {31'd0, bus2.SRAM_WE_N}, 32'd0);
        rst = 1'b1;
        nextCycle();
        checkOutput("midrst_wen", {31'd0, bus2.SRAM_WE_N}, 32'd1);
        checkOutput("midrst_oe", {31'd0, bus2.SRAM_DQ_oe}, 32'd0);
        checkOutput("midrst_addr", {14'd0, bus2.SRAM_ADDR}, 32'd0);
        checkOutput("midrst_rdata", bus2.rdata, 32'd0);
        rst = 1'b0;
        applyStimulus(2, 1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("midrst_idle_ready", {31'd0, bus2.ready}, 32'd1);
        nextCycle();
        measureStall(2, 1'b1, 1'b0, 32'd1028, 32'd0, lowCount);
        checkOutput("midrst_load_stall", 32'(lowCount), 32'd5);
        checkOutput("midrst_load_rdata", bus2.rdata, 32'hDEAD2222);
        goIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
